// File: rtl/burst_master_port_if.sv
// Bus bundle for burst_master_port: user request side, arbiter handshake and
// serial slave lanes. master modport is the port's view, slave the environment's.
interface burst_master_port_if #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
);
  logic                 start;
  logic [1:0]           instruction;
  logic [ADDR_LEN-1:0]  address;
  logic [SLAVE_LEN-1:0] slave_select;
  logic [BURST_LEN-1:0] burst_num;
  logic [DATA_LEN-1:0]  wdata;
  logic                 wdata_ack;
  logic [DATA_LEN-1:0]  rdata;
  logic                 rdata_valid;
  logic                 done;
  logic                 error;
  logic                 master_ready;
  logic                 approval_request;
  logic                 approval_grant;
  logic                 busy;
  logic                 tx_slave_select;
  logic                 tx_address;
  logic                 tx_data;
  logic                 master_valid;
  logic                 write_en;
  logic                 read_en;
  logic                 slave_ready;
  logic                 slave_valid;
  logic                 rx_data;
  logic                 tx_done;

  modport master (
    input  start, instruction, address, slave_select, burst_num, wdata,
           approval_grant, busy, slave_ready, slave_valid, rx_data,
    output wdata_ack, rdata, rdata_valid, done, error, master_ready,
           approval_request, tx_slave_select, tx_address, tx_data,
           master_valid, write_en, read_en, tx_done
  );

  modport slave (
    output start, instruction, address, slave_select, burst_num, wdata,
           approval_grant, busy, slave_ready, slave_valid, rx_data,
    input  wdata_ack, rdata, rdata_valid, done, error, master_ready,
           approval_request, tx_slave_select, tx_address, tx_data,
           master_valid, write_en, read_en, tx_done
  );
endinterface

// File: rtl/burst_master_port.sv
// Burst bus master: arbitration, serial select/address/data lanes, read deserialiser.
// Optional macro BMP_TIMEOUT_EN adds a wait-timeout abort in WAIT/RDATA.
module burst_master_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int TIMEOUT_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  burst_master_port_if.master bus
);
  localparam int MAX_LEN = (ADDR_LEN > DATA_LEN)
                         ? ((ADDR_LEN > SLAVE_LEN) ? ADDR_LEN : SLAVE_LEN)
                         : ((DATA_LEN > SLAVE_LEN) ? DATA_LEN : SLAVE_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SEL, S_ADDR, S_WAIT, S_WDATA, S_RDATA, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic                 r_isWrite;
  logic [SLAVE_LEN-1:0] r_sel;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [DATA_LEN-1:0]  r_shift;
  logic [DATA_LEN-1:0]  r_rdata;
  logic [BURST_LEN-1:0] r_burst;
  logic [BURST_LEN-1:0] r_beatCnt;
  logic [CNT_W-1:0]     r_bitCnt;
  logic                 r_rdataValid;
  logic                 r_error;

  logic                 w_opValid, w_selLast, w_addrLast, w_dataLast, w_beatLast;
  logic                 w_busPhase, w_enPhase, w_abort, w_tmoHit;
  logic [DATA_LEN-1:0]  w_rxShift;

  assign w_opValid  = (bus.instruction == 2'b01) || (bus.instruction == 2'b10);
  assign w_selLast  = (r_bitCnt == CNT_W'(SLAVE_LEN - 1));
  assign w_addrLast = (r_bitCnt == CNT_W'(ADDR_LEN - 1));
  assign w_dataLast = (r_bitCnt == CNT_W'(DATA_LEN - 1));
  assign w_beatLast = (r_beatCnt == r_burst - BURST_LEN'(1));
  assign w_busPhase = r_state inside {S_SEL, S_ADDR, S_WAIT, S_WDATA, S_RDATA};
  assign w_enPhase  = w_busPhase || (r_state == S_DONE);
  assign w_rxShift  = (r_shift << 1) | DATA_LEN'(bus.rx_data);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start && w_opValid) w_next = S_REQ;
      S_REQ:   if (bus.approval_grant && !bus.busy) w_next = S_SEL;
      S_SEL:   if (w_selLast) w_next = S_ADDR;
      S_ADDR:  if (w_addrLast) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.slave_ready) w_next = r_isWrite ? S_WDATA : S_RDATA;
        else if (w_tmoHit) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_WDATA: if (w_dataLast) w_next = w_beatLast ? S_DONE : S_WAIT;
      S_RDATA: begin
        if (bus.slave_valid && w_dataLast) w_next = w_beatLast ? S_DONE : S_WAIT;
        else if (!bus.slave_valid && w_tmoHit) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Losing the grant anywhere on the bus outranks every other transition.
    if (w_busPhase && !bus.approval_grant) begin
      w_next  = S_DONE;
      w_abort = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_isWrite    <= 1'b0;
      r_sel        <= '0;
      r_addr       <= '0;
      r_shift      <= '0;
      r_rdata      <= '0;
      r_burst      <= '0;
      r_beatCnt    <= '0;
      r_bitCnt     <= '0;
      r_rdataValid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_rdataValid <= 1'b0;
      if (w_next != r_state) r_bitCnt <= '0;
      else if ((r_state inside {S_SEL, S_ADDR, S_WDATA}) ||
               (r_state == S_RDATA && bus.slave_valid))
        r_bitCnt <= r_bitCnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_opValid) begin
            r_isWrite <= (bus.instruction == 2'b01);
            r_sel     <= bus.slave_select;
            r_addr    <= bus.address;
            r_burst   <= (bus.burst_num == '0) ? BURST_LEN'(1) : bus.burst_num;
            r_beatCnt <= '0;
            r_error   <= 1'b0;
          end
        end
        S_SEL:  r_sel  <= r_sel << 1;
        S_ADDR: r_addr <= r_addr << 1;
        S_WAIT: if (bus.slave_ready && r_isWrite) r_shift <= bus.wdata;
        S_WDATA: begin
          r_shift <= r_shift << 1;
          if (w_dataLast) r_beatCnt <= r_beatCnt + BURST_LEN'(1);
        end
        S_RDATA: begin
          if (bus.slave_valid) begin
            r_shift <= w_rxShift;
            // An aborted beat never reaches rdata.
            if (w_dataLast && !w_abort) begin
              r_rdata      <= w_rxShift;
              r_rdataValid <= 1'b1;
              r_beatCnt    <= r_beatCnt + BURST_LEN'(1);
            end
          end
        end
        default: ;
      endcase
      if (w_abort) r_error <= 1'b1;
    end
  end

`ifdef BMP_TIMEOUT_EN
  logic [TIMEOUT_LEN-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset || (w_next != r_state) || bus.slave_ready || bus.slave_valid)
      r_tmo <= '0;
    else if (r_state == S_WAIT || r_state == S_RDATA)
      r_tmo <= r_tmo + TIMEOUT_LEN'(1);
  end

  assign w_tmoHit = &r_tmo;
`else
  // Never fires; the comparison only keeps TIMEOUT_LEN referenced here.
  assign w_tmoHit = (TIMEOUT_LEN < 0);
`endif

  always_comb begin
    bus.master_ready     = (r_state == S_IDLE);
    bus.approval_request = (r_state != S_IDLE);
    bus.write_en         = w_enPhase && r_isWrite;
    bus.read_en          = w_enPhase && !r_isWrite;
    bus.master_valid     = 1'b0;
    bus.tx_slave_select  = 1'b0;
    bus.tx_address       = 1'b0;
    bus.tx_data          = 1'b0;
    bus.wdata_ack        = 1'b0;
    bus.tx_done          = 1'b0;
    bus.done             = 1'b0;
    case (r_state)
      S_SEL: begin
        bus.master_valid    = 1'b1;
        bus.tx_slave_select = r_sel[SLAVE_LEN-1];
      end
      S_ADDR: begin
        bus.master_valid = 1'b1;
        bus.tx_address   = r_addr[ADDR_LEN-1];
      end
      S_WAIT:  bus.wdata_ack = r_isWrite && (w_next == S_WDATA);
      S_WDATA: begin
        bus.master_valid = 1'b1;
        bus.tx_data      = r_shift[DATA_LEN-1];
      end
      S_DONE: begin
        bus.tx_done = 1'b1;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdataValid;
  assign bus.error       = r_error;
endmodule

// File: tb/tb_burst_master_port.sv
// Self-checking bench for burst_master_port: table vectors, random transactions
// against a lane-stream model, and hand sequences for reset, no-op and timeout.
module tb_burst_master_port;
  localparam int SL = 2;
  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;
  localparam int TL = 4;
  localparam logic [12+DL:0] IDLE_VEC = {1'b1, {(12+DL){1'b0}}};

  typedef struct {
    logic [1:0]      instr;
    logic [SL-1:0]   sel;
    logic [AL-1:0]   addr;
    logic [BL-1:0]   burst;
    logic [4*DL-1:0] words;
    int              busyCyc;
    int              dropAt;
    logic            expErr;
    int              expBeats;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  burst_master_port_if #(.SLAVE_LEN(SL), .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) bus ();

  burst_master_port #(
    .SLAVE_LEN(SL), .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL), .TIMEOUT_LEN(TL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  // Monitor keeps cumulative records; each transaction looks at what it added.
  bit               qSel[$], qAddr[$], qData[$];
  logic [DL-1:0]    qRd[$];
  logic             qDoneErr[$];
  int               ackCnt = 0, txDoneBad = 0, enBad = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.master_valid) begin
        qSel.push_back(bus.tx_slave_select);
        qAddr.push_back(bus.tx_address);
        qData.push_back(bus.tx_data);
      end
      if (bus.wdata_ack) ackCnt++;
      if (bus.rdata_valid) qRd.push_back(bus.rdata);
      if (bus.done) qDoneErr.push_back(bus.error);
      if (bus.tx_done != bus.done) txDoneBad++;
      if (bus.write_en && bus.read_en) enBad++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12+DL:0] outVec();
    return {bus.master_ready, bus.approval_request, bus.master_valid, bus.write_en,
            bus.read_en, bus.tx_done, bus.done, bus.error, bus.wdata_ack,
            bus.rdata_valid, bus.tx_slave_select, bus.tx_address, bus.tx_data, bus.rdata};
  endfunction

  // Reference: lane value at the i-th valid cycle of a transaction.
  function automatic logic expBit(input vec_t v, input int lane, input int i);
    int j;
    logic [DL-1:0] wd;
    if (i < SL) return (lane == 0) ? v.sel[SL-1-i] : 1'b0;
    if (i < SL + AL) return (lane == 1) ? v.addr[AL-1-(i-SL)] : 1'b0;
    j  = i - SL - AL;
    wd = v.words[(j/DL)*DL +: DL];
    return (lane == 2) ? wd[DL-1-(j%DL)] : 1'b0;
  endfunction

  task automatic startTxn(input vec_t v);
    bus.instruction    = v.instr;
    bus.address        = v.addr;
    bus.slave_select   = v.sel;
    bus.burst_num      = v.burst;
    bus.approval_grant = 1'b1;
    bus.busy           = (v.busyCyc > 0);
    bus.start          = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int b0Sel, b0Ack, b0Rd, b0Done, b0Tx, nBits, expN, expAcks, expRd;
    logic [63:0] aS, aA, aD, eS, eA, eD;
    logic [DL-1:0] wd;
    bit isW;
    isW    = (v.instr == 2'b01);
    b0Sel  = qSel.size();
    b0Ack  = ackCnt;
    b0Rd   = qRd.size();
    b0Done = qDoneErr.size();
    b0Tx   = txDoneBad;
    startTxn(v);
    checkOutput("errClr", bus.error, 1'b0);
    checkOutput("reqState", {bus.approval_request, bus.master_ready}, 2'b10);
    for (int k = 1; k < v.busyCyc; k++) step();
    bus.busy = 1'b0;
    step();
    checkOutput("selStart", bus.master_valid, 1'b1);
    if (v.dropAt >= 0) begin
      repeat (SL + v.dropAt) step();
      bus.approval_grant = 1'b0;
      step();
      checkOutput("abortDone", {bus.done, bus.error}, 2'b11);
      bus.approval_grant = 1'b1;
      step();
    end else begin
      repeat (SL + AL) step();
      for (int b = 0; b < v.expBeats; b++) begin
        wd        = v.words[b*DL +: DL];
        bus.wdata = wd;
        repeat ($urandom_range(0, 3)) step();
        bus.slave_ready = 1'b1;
        step();
        bus.slave_ready = 1'b0;
        if (isW) repeat (DL) step();
        else begin
          int got = 0;
          while (got < DL) begin
            if ($urandom_range(0, 2) == 0) bus.slave_valid = 1'b0;
            else begin
              bus.slave_valid = 1'b1;
              bus.rx_data     = wd[DL-1-got];
              got++;
            end
            step();
          end
          bus.slave_valid = 1'b0;
        end
      end
      step();
    end
    checkOutput("readyAfter", bus.master_ready, 1'b1);

    expN    = (v.dropAt >= 0) ? SL + v.dropAt + 1 : SL + AL + (isW ? v.expBeats * DL : 0);
    expAcks = (isW && v.dropAt < 0) ? v.expBeats : 0;
    expRd   = (!isW && v.dropAt < 0) ? v.expBeats : 0;
    nBits   = qSel.size() - b0Sel;
    checkOutput("validBits", nBits, expN);
    {aS, aA, aD, eS, eA, eD} = '0;
    for (int i = 0; i < nBits && i < 64; i++) begin
      aS = {aS[62:0], qSel[b0Sel+i]};
      aA = {aA[62:0], qAddr[b0Sel+i]};
      aD = {aD[62:0], qData[b0Sel+i]};
    end
    for (int i = 0; i < expN; i++) begin
      eS = {eS[62:0], expBit(v, 0, i)};
      eA = {eA[62:0], expBit(v, 1, i)};
      eD = {eD[62:0], expBit(v, 2, i)};
    end
    checkOutput("selLane", aS, eS);
    checkOutput("addrLane", aA, eA);
    checkOutput("dataLane", aD, eD);
    checkOutput("wdataAcks", ackCnt - b0Ack, expAcks);
    checkOutput("rdataCount", qRd.size() - b0Rd, expRd);
    if (qRd.size() - b0Rd == expRd)
      for (int i = 0; i < expRd; i++) checkOutput("rdataValue", qRd[b0Rd+i], v.words[i*DL +: DL]);
    checkOutput("doneCount", qDoneErr.size() - b0Done, 1);
    if (qDoneErr.size() - b0Done == 1) checkOutput("doneError", qDoneErr[b0Done], v.expErr);
    checkOutput("txDoneSync", txDoneBad - b0Tx, 0);
    checkOutput("enExclusive", enBad, 0);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    int d0;
    vecs[0] = '{2'b01, 2'b10, 12'hA5C, 12'd1, 32'h0000_003C, 0, -1, 1'b0, 1};
    vecs[1] = '{2'b10, 2'b01, 12'h123, 12'd3, 32'h0033_2211, 0, -1, 1'b0, 3};
    vecs[2] = '{2'b01, 2'b11, 12'h0FF, 12'd0, 32'h0000_00A5, 0, -1, 1'b0, 1};
    vecs[3] = '{2'b01, 2'b00, 12'h800, 12'd2, 32'h0000_C35A, 5, -1, 1'b0, 2};
    vecs[4] = '{2'b10, 2'b10, 12'h7E1, 12'd2, 32'h0000_4477, 0,  5, 1'b1, 0};
    vecs[5] = '{2'b10, 2'b11, 12'hFFF, 12'd1, 32'h0000_0080, 0, -1, 1'b0, 1};

    reset = 1'b1;
    bus.start = 1'b0; bus.instruction = 2'b00; bus.address = '0; bus.slave_select = '0;
    bus.burst_num = '0; bus.wdata = '0; bus.approval_grant = 1'b0; bus.busy = 1'b0;
    bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
    repeat (3) step();
    checkOutput("resetState", outVec(), IDLE_VEC);
    reset = 1'b0;
    step();

    bus.instruction = 2'b11;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checkOutput("noopIgnored", {bus.master_ready, bus.approval_request}, 2'b10);

    for (int t = 0; t < 6; t++) applyStimulus(vecs[t]);

    for (int r = 0; r < 8; r++) begin
      rv.instr    = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      rv.sel      = SL'($urandom_range(0, (1 << SL) - 1));
      rv.addr     = AL'($urandom_range(0, (1 << AL) - 1));
      rv.burst    = BL'($urandom_range(0, 4));
      rv.words    = $urandom;
      rv.busyCyc  = $urandom_range(0, 2);
      rv.dropAt   = -1;
      rv.expErr   = 1'b0;
      rv.expBeats = (rv.burst == '0) ? 1 : int'(rv.burst);
      applyStimulus(rv);
    end

    // Slave never becomes ready in WAIT.
    d0 = qDoneErr.size();
    rv = '{2'b01, 2'b01, 12'h321, 12'd1, 32'h0000_0042, 0, -1, 1'b0, 1};
    startTxn(rv);
    step();
    repeat (SL + AL) step();
`ifdef BMP_TIMEOUT_EN
    begin
      int waited = 0;
      while (!bus.done && waited < 60) begin
        step();
        waited++;
      end
      checkOutput("tmoDone", {bus.done, bus.error}, 2'b11);
      checkOutput("tmoWindow", (waited >= 12 && waited <= 20), 1'b1);
      step();
    end
`else
    repeat (100) step();
    checkOutput("noTimeout", {bus.done, bus.write_en, bus.master_valid, bus.master_ready}, 4'b0100);
    checkOutput("noTimeoutDone", qDoneErr.size() - d0, 0);
    bus.approval_grant = 1'b0;
    step();
    bus.approval_grant = 1'b1;
    step();
`endif

    // Reset in the middle of a write data beat.
    rv = '{2'b01, 2'b10, 12'h5A5, 12'd2, 32'h0000_F00F, 0, -1, 1'b0, 2};
    startTxn(rv);
    step();
    repeat (SL + AL) step();
    bus.wdata = 8'h0F;
    bus.slave_ready = 1'b1;
    step();
    bus.slave_ready = 1'b0;
    repeat (3) step();
    checkOutput("inWdata", bus.master_valid, 1'b1);
    d0 = qDoneErr.size();
    reset = 1'b1;
    step();
    checkOutput("resetMidWdata", outVec(), IDLE_VEC);
    reset = 1'b0;
    repeat (3) step();
    checkOutput("resetNoDone", qDoneErr.size() - d0, 0);
    checkOutput("resetIdle", {bus.master_ready, bus.approval_request, bus.write_en}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
